// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared types and constants for the MMU refill engine
package mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_FAIL,
        ST_DRAIN
    } refill_state_e;

    localparam int ENT_VALID = 1;
    localparam int ENT_WRITE = 2;

    // Low address bits below the table base: entry index plus byte offset within a word.
    function automatic int a_width(input int rv, input int nmmu);
        return $clog2(4 * nmmu) + $clog2(rv / 8);
    endfunction

endpackage

// File: rtl/mmu_refill.sv
// rtl/mmu_refill.sv - hardware MMU miss refill engine and MMU register-port mux
module mmu_refill
    import mmu_pkg::*;
#(
    parameter int RV   = 16,
    parameter int PA   = RV,
    parameter int VA   = RV,
    parameter int NMMU = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_write,
    input  logic [RV-1:0]             cfg_data,
    output logic [RV-1:0]             cfg_read,
    input  logic                      miss,
    input  logic [$clog2(NMMU)+1:0]   miss_idx,
    output logic                      busy,
    output logic                      refill_done,
    output logic                      refill_fault,
    output logic                      mem_req,
    output logic [PA-1:0]             mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [RV-1:0]             mem_rdata,
    input  logic                      mem_err,
    input  logic                      sw_reg_write,
    input  logic [RV-1:0]             sw_reg_data,
    output logic                      mmu_reg_write,
    output logic [RV-1:0]             mmu_reg_data
);

    localparam int A  = a_width(RV, NMMU);
    localparam int IW = $clog2(NMMU) + 2;
    localparam int BW = $clog2(RV / 8);

    refill_state_e     state_q, state_d;
    logic              en_q, en_d;
    logic [RV-A-1:0]   base_q, base_d;
    logic [PA-1:0]     addr_q, addr_d;
    logic [RV-2:0]     rdata_q, rdata_d;
    logic [RV-1:0]     entry_addr;
    logic              eng_write;

    // Bit 0 of the entry is ignored and always written back as 1.
    logic [VA-1:0]     unused_va;
    assign unused_va = {VA{mem_rdata[0]}};

    assign entry_addr = {base_q, miss_idx[IW-1:0], {BW{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            base_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        base_d  = base_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;

        if (cfg_write) begin
            en_d   = cfg_data[0];
            base_d = cfg_data[RV-1:A];
        end

        case (state_q)
            ST_IDLE: begin
                if (miss && en_q) begin
                    addr_d  = PA'(entry_addr);
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // An abort in the grant cycle still leaves a read in flight, so drain it.
                if (sw_reg_write) begin
                    state_d = mem_gnt ? ST_DRAIN : ST_IDLE;
                end else if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (sw_reg_write) begin
                        state_d = ST_IDLE;
                    end else if (!mem_err && mem_rdata[ENT_VALID]) begin
                        rdata_d = mem_rdata[RV-1:1];
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (sw_reg_write) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_FAIL:  state_d = ST_IDLE;
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eng_write     = (state_q == ST_WRITE) && !sw_reg_write;
        mmu_reg_write = eng_write || sw_reg_write;
        mmu_reg_data  = eng_write ? {rdata_q, 1'b1} : sw_reg_data;
        refill_done   = eng_write;
        refill_fault  = (state_q == ST_FAIL) && !sw_reg_write;
        busy          = (state_q != ST_IDLE);
        mem_req       = (state_q == ST_REQ);
        mem_addr      = addr_q;
        cfg_read      = {base_q, {(A-1){1'b0}}, en_q};
    end

endmodule

// File: tb/tb_mmu_refill.sv
// tb/tb_mmu_refill.sv - directed self-checking bench for mmu_refill
module tb_mmu_refill;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_write;
    logic [15:0] cfg_data;
    logic [15:0] cfg_read;
    logic        miss;
    logic [4:0]  miss_idx;
    logic        busy, refill_done, refill_fault, mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [15:0] mem_rdata;
    logic        sw_reg_write;
    logic [15:0] sw_reg_data;
    logic        mmu_reg_write;
    logic [15:0] mmu_reg_data;

    int vectors = 0;
    int miscompares = 0;

    mmu_refill dut (
        .clk(clk), .reset(reset),
        .cfg_write(cfg_write), .cfg_data(cfg_data), .cfg_read(cfg_read),
        .miss(miss), .miss_idx(miss_idx),
        .busy(busy), .refill_done(refill_done), .refill_fault(refill_fault),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .sw_reg_write(sw_reg_write), .sw_reg_data(sw_reg_data),
        .mmu_reg_write(mmu_reg_write), .mmu_reg_data(mmu_reg_data)
    );

    always #5 clk = ~clk;

    // {busy, refill_done, refill_fault, mem_req, mmu_reg_write}
    logic [4:0] flags;
    assign flags = {busy, refill_done, refill_fault, mem_req, mmu_reg_write};

    task automatic clr();
        cfg_write    = 1'b0;
        cfg_data     = 16'h0;
        miss         = 1'b0;
        miss_idx     = 5'h0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 16'h0;
        mem_err      = 1'b0;
        sw_reg_write = 1'b0;
        sw_reg_data  = 16'h0;
    endtask

    task automatic write_cfg(input logic [15:0] d);
        cfg_write = 1'b1;
        cfg_data  = d;
        @(negedge clk);
        cfg_write = 1'b0;
        cfg_data  = 16'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr();
        #1;
        vectors++;
        if (flags !== 5'b00000) begin
            $display("FAIL reset_flags got %b exp %b", flags, 5'b00000);
            miscompares++;
        end
        vectors++;
        if (cfg_read !== 16'h0000 || mem_addr !== 16'h0000) begin
            $display("FAIL reset_regs got cfg %h addr %h exp 0000 0000", cfg_read, mem_addr);
            miscompares++;
        end
        sw_reg_write = 1'b1;
        sw_reg_data  = 16'h1234;
        #1;
        vectors++;
        if (mmu_reg_write !== 1'b1 || mmu_reg_data !== 16'h1234) begin
            $display("FAIL reset_passthru got %b %h exp 1 1234", mmu_reg_write, mmu_reg_data);
            miscompares++;
        end
        clr();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cfg();
        write_cfg(16'h0047);
        #1;
        vectors++;
        if (cfg_read !== 16'h0041) begin
            $display("FAIL cfg_mask got %h exp %h", cfg_read, 16'h0041);
            miscompares++;
        end
        @(negedge clk);
    endtask

    // One refill with immediate grant; response in the WAIT cycle.
    task automatic test_refill(input string name, input logic [15:0] rd, input logic err,
                               input logic [4:0] exp_c3, input logic [15:0] exp_data);
        miss = 1'b1; miss_idx = 5'b01011;
        #1;
        vectors++;
        if (flags !== 5'b00000) begin
            $display("FAIL %s_c0 got %b exp %b", name, flags, 5'b00000);
            miscompares++;
        end
        @(negedge clk);
        miss = 1'b0; mem_gnt = 1'b1;
        #1;
        vectors++;
        if (flags !== 5'b10010 || mem_addr !== 16'h0056) begin
            $display("FAIL %s_c1 got %b addr %h exp %b addr 0056", name, flags, mem_addr, 5'b10010);
            miscompares++;
        end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd; mem_err = err;
        #1;
        vectors++;
        if (flags !== 5'b10000) begin
            $display("FAIL %s_c2 got %b exp %b", name, flags, 5'b10000);
            miscompares++;
        end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 16'h0; mem_err = 1'b0;
        #1;
        vectors++;
        if (flags !== exp_c3 || (exp_c3[0] && mmu_reg_data !== exp_data)) begin
            $display("FAIL %s_c3 got %b data %h exp %b data %h", name, flags, mmu_reg_data, exp_c3, exp_data);
            miscompares++;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (flags !== 5'b00000) begin
            $display("FAIL %s_c4 got %b exp %b", name, flags, 5'b00000);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_gnt_delay();
        miss = 1'b1; miss_idx = 5'b10101;
        @(negedge clk);
        miss = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_gnt = (i == 5);
            #1;
            vectors++;
            if (flags !== 5'b10010 || mem_addr !== 16'h006A) begin
                $display("FAIL gnt_delay_req%0d got %b addr %h exp %b addr 006a", i, flags, mem_addr, 5'b10010);
                miscompares++;
            end
            @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1236;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        vectors++;
        if (flags !== 5'b11001 || mmu_reg_data !== 16'h1237) begin
            $display("FAIL gnt_delay_write got %b data %h exp %b data 1237", flags, mmu_reg_data, 5'b11001);
            miscompares++;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (flags !== 5'b00000) begin
            $display("FAIL gnt_delay_idle got %b exp %b", flags, 5'b00000);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_abort_wait();
        miss = 1'b1; miss_idx = 5'b01011;
        @(negedge clk);
        miss = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; sw_reg_write = 1'b1; sw_reg_data = 16'h0003;
        #1;
        vectors++;
        if (flags !== 5'b10001 || mmu_reg_data !== 16'h0003) begin
            $display("FAIL abort_wait_sw got %b data %h exp %b data 0003", flags, mmu_reg_data, 5'b10001);
            miscompares++;
        end
        @(negedge clk);
        sw_reg_write = 1'b0; sw_reg_data = 16'h0;
        #1;
        vectors++;
        if (flags !== 5'b10000) begin
            $display("FAIL abort_drain got %b exp %b", flags, 5'b10000);
            miscompares++;
        end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 16'hA006;
        #1;
        vectors++;
        if (flags !== 5'b10000) begin
            $display("FAIL abort_drain_rvalid got %b exp %b", flags, 5'b10000);
            miscompares++;
        end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 16'h0;
        #1;
        vectors++;
        if (flags !== 5'b00000) begin
            $display("FAIL abort_idle got %b exp %b", flags, 5'b00000);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_abort_req();
        miss = 1'b1; miss_idx = 5'b00001;
        @(negedge clk);
        miss = 1'b0; sw_reg_write = 1'b1; sw_reg_data = 16'h5555;
        #1;
        vectors++;
        if (flags !== 5'b10011 || mmu_reg_data !== 16'h5555) begin
            $display("FAIL abort_req got %b data %h exp %b data 5555", flags, mmu_reg_data, 5'b10011);
            miscompares++;
        end
        @(negedge clk);
        sw_reg_write = 1'b0; sw_reg_data = 16'h0;
        #1;
        vectors++;
        if (flags !== 5'b00000) begin
            $display("FAIL abort_req_idle got %b exp %b", flags, 5'b00000);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_disabled();
        write_cfg(16'h0040);
        miss = 1'b1; miss_idx = 5'b01011;
        @(negedge clk);
        miss = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (flags !== 5'b00000) begin
                $display("FAIL disabled_c%0d got %b exp %b", i + 1, flags, 5'b00000);
                miscompares++;
            end
            @(negedge clk);
        end
        write_cfg(16'h0041);
    endtask

    task automatic test_reset_mid();
        miss = 1'b1; miss_idx = 5'b01011;
        @(negedge clk);
        miss = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        vectors++;
        if (flags !== 5'b10000) begin
            $display("FAIL reset_mid_wait got %b exp %b", flags, 5'b10000);
            miscompares++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (flags !== 5'b00000 || cfg_read !== 16'h0000 || mem_addr !== 16'h0000) begin
            $display("FAIL reset_mid got %b cfg %h addr %h exp 00000 0000 0000", flags, cfg_read, mem_addr);
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hA006;
        #1;
        vectors++;
        if (flags !== 5'b00000) begin
            $display("FAIL reset_mid_late_rvalid got %b exp %b", flags, 5'b00000);
            miscompares++;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        vectors++;
        if (flags !== 5'b00000) begin
            $display("FAIL reset_mid_after got %b exp %b", flags, 5'b00000);
            miscompares++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_refill("ok", 16'hA006, 1'b0, 5'b11001, 16'hA007);
        test_refill("invalid", 16'hA004, 1'b0, 5'b10100, 16'h0000);
        test_refill("mem_err", 16'hA006, 1'b1, 5'b10100, 16'h0000);
        test_gnt_delay();
        test_abort_wait();
        test_abort_req();
        test_disabled();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmu_refill.md
# mmu_refill

Hardware refill engine for the small segment MMU. On a qualified MMU miss it fetches the mapping entry for the faulting {ins, sup, vpage} index from an in-memory table and writes it into the MMU through the MMU register-write port, so the core stalls instead of trapping. It sits between the core's MMU fault path, the memory arbiter and the MMU register port, and owns the mux onto that port.

## Interface
Parameters:
- RV, 16, datapath width
- PA, RV, physical address width
- VA, RV, virtual address width
- NMMU, 8, entries per MMU bank (4 banks: ins/data × sup/user)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_write  in  1  write the config register
- cfg_data  in  RV  bit0 enable; bits [RV-1:A] table base, A = $clog2(4*NMMU)+$clog2(RV/8)
- cfg_read  out  RV  {base, zeros, enable}
- miss  in  1  MMU miss fault this cycle (mmu_miss_fault & mmu_fault)
- miss_idx  in  $clog2(NMMU)+2  {is_pc, eff_sup, vpage} of the miss
- busy  out  1  refill in progress; core stalls
- refill_done  out  1  one-cycle pulse, entry installed
- refill_fault  out  1  one-cycle pulse, refill failed; core takes the MMU trap
- mem_req  out  1  read request
- mem_addr  out  PA  byte address of the entry
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  RV  entry word
- mem_err  in  1  bus error, qualified by mem_rvalid
- sw_reg_write  in  1  core MMU register write
- sw_reg_data  in  RV  core MMU register data
- mmu_reg_write  out  1  to MMU reg_write
- mmu_reg_data  out  RV  to MMU reg_data

## Operation
- Entry address: {base[PA-1:A], idx, $clog2(RV/8) zeros}; base zero-extended when PA>RV.
- Entry format: [RV-1:RV-(PA-UNTOUCHED)] physical page, bit2 writeable, bit1 valid, bit0 ignored.
- States: IDLE, REQ, WAIT, WRITE, FAIL, DRAIN.
- IDLE: miss & enable → latch idx, REQ. Miss with enable=0 ignored (software trap path).
- REQ: mem_req=1, mem_addr held stable; mem_gnt → WAIT.
- WAIT: mem_rvalid & !mem_err & rdata[1] → latch rdata, WRITE; mem_rvalid & (mem_err | !rdata[1]) → FAIL.
- WRITE: mmu_reg_write=1, mmu_reg_data = {rdata[RV-1:1], 1'b1}, refill_done=1 → IDLE.
- FAIL: refill_fault=1, no MMU write → IDLE.
- busy = (state != IDLE).
- Port mux: engine drives MMU port only in WRITE; otherwise sw_reg_write/sw_reg_data pass through unregistered.
- Abort: sw_reg_write while busy always passes through (it rewrites the MMU fault registers). From REQ → IDLE; from WAIT → DRAIN; from WRITE/FAIL the software write wins, no engine write, no pulse → IDLE.
- DRAIN: wait for mem_rvalid, discard data → IDLE; no pulses.
- miss while busy: ignored.
- cfg_write while busy: register updates immediately; the current refill keeps its latched address; clearing enable does not abort.

## Timing
- Reset: state IDLE, enable 0, base 0; all outputs 0 except pass-through of sw_reg_*.
- Fastest path (gnt in REQ cycle, rvalid next): miss c0, REQ c1, WAIT c2, WRITE c3, IDLE c4; busy high c1–c3.
- mem_req registered; asserted from the cycle after miss and held until the gnt cycle inclusive.
- At most one outstanding read.
- Asynchronous reset mid-refill returns to IDLE immediately; an in-flight response arriving after reset is ignored, because rvalid is only sampled in WAIT/DRAIN.

## Structure
- Package mmu_pkg: refill state enum, entry bit positions (ENT_VALID=1, ENT_WRITE=2), A-width function of RV/NMMU.
- Single module, no sub-module; the FSM and port mux are one unit.

## Test plan
- Defaults, base=0x0040, miss_idx=6'b01_011, gnt immediate, rdata=0xA006 → mem_addr=0x0056; mmu_reg_write with data 0xA007 at c3; refill_done c3; busy c1–c3.
- Same with rdata=0xA004 (valid=0) → refill_fault pulse, no mmu_reg_write.
- mem_rvalid with mem_err=1 → refill_fault, no write.
- gnt held off 5 cycles → mem_req/mem_addr stable for all 6 cycles; completes normally.
- sw_reg_write=1 with data 0x0003 during WAIT → passes through; DRAIN discards the later rvalid; no pulses; returns to IDLE.
- enable=0 and miss → no mem_req, busy stays 0; reset asserted in WAIT → IDLE, outputs 0.
